// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the instruction/data memory arbiter.
//   arb_state_e      - arbiter FSM state encoding
//   SIZE_*           - access size codes carried on d_size / m_size
//   NOP_INSN         - instruction returned to fetch when its access times out
//   TIMEOUT_DEFAULT  - default wait budget, in BUSY cycles
//   cnt_width()      - bits needed for a counter that reaches limit-1
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_D  = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts cycles spent waiting on memory.
//   clk, rst  - clock, synchronous active-high reset
//   clr_i     - return count to zero (takes priority over en_i)
//   en_i      - advance the count by one this cycle
//   tc_o      - count has reached LIMIT-1; the count holds there
module wait_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned   W      = cnt_width(LIMIT);
    localparam logic [W-1:0]  TC_VAL = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and the
// data (load/store) stage, one access outstanding at a time.
//   clk, rst                 - clock, synchronous active-high reset
//   if_req/if_addr           - fetch request (held until if_ack)
//   if_rdata/if_ack          - fetched word, one-cycle completion pulse
//   d_req/d_we/d_size/d_addr/d_wdata - data request (held until d_ack)
//   d_rdata/d_ack/d_err      - load data, completion pulse, timeout/bad-size
//   m_req/m_we/m_size/m_addr/m_wdata - memory request and attributes
//   m_rdata/m_ready          - memory read data, completion handshake
//   stall_fetch/stall_pipe   - requester waiting on its ack
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | no access; arbitrate and latch the winner's attributes
//   ST_BUSY_IF | fetch access on the memory port, waiting for m_ready
//   ST_BUSY_D  | data access on the memory port, waiting for m_ready
//   ST_RESP    | one-cycle ack to the granted requester, no new grant
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        m_req,
    output logic        m_we,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        stall_fetch,
    output logic        stall_pipe
);

    arb_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        gnt_data_q, gnt_data_d;    // owner of the current access
    logic        last_data_q, last_data_d;  // last grant went to data
    logic [31:0] resp_q, resp_d;
    logic        err_q, err_d;

    logic busy;
    logic grant_data;
    logic timer_tc;

    assign busy = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_D);

    // Data has priority in a conflict, except straight after a data grant,
    // so a stream of loads/stores cannot starve fetch.
    assign grant_data = d_req && (!if_req || !last_data_q);

    wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == ST_IDLE),
        .en_i  (busy && !m_ready),
        .tc_o  (timer_tc)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        we_d        = we_q;
        gnt_data_d  = gnt_data_q;
        last_data_d = last_data_q;
        resp_d      = resp_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    addr_d      = d_addr;
                    wdata_d     = d_wdata;
                    size_d      = d_size;
                    we_d        = d_we;
                    gnt_data_d  = 1'b1;
                    last_data_d = 1'b1;
                    err_d       = 1'b0;
                    if (d_size == SIZE_RSVD) begin
                        // Reserved size never reaches memory.
                        resp_d  = '0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY_D;
                    end
                end else if (if_req) begin
                    addr_d      = if_addr;
                    wdata_d     = '0;
                    size_d      = SIZE_WORD;
                    we_d        = 1'b0;
                    gnt_data_d  = 1'b0;
                    last_data_d = 1'b0;
                    err_d       = 1'b0;
                    state_d     = ST_BUSY_IF;
                end
            end
            ST_BUSY_IF, ST_BUSY_D: begin
                // A ready arriving on the last allowed cycle still completes.
                if (m_ready) begin
                    resp_d  = we_q ? 32'h0 : m_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timer_tc) begin
                    // Fetch gets a NOP so the pipeline keeps moving.
                    resp_d  = gnt_data_q ? 32'h0 : NOP_INSN;
                    err_d   = gnt_data_q;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= SIZE_WORD;
            we_q        <= 1'b0;
            gnt_data_q  <= 1'b0;
            last_data_q <= 1'b0;
            resp_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            we_q        <= we_d;
            gnt_data_q  <= gnt_data_d;
            last_data_q <= last_data_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
        end
    end

    assign m_req   = busy;
    assign m_we    = busy && we_q;
    assign m_size  = size_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;

    assign if_ack   = (state_q == ST_RESP) && !gnt_data_q;
    assign d_ack    = (state_q == ST_RESP) && gnt_data_q;
    assign d_err    = d_ack && err_q;
    assign if_rdata = resp_q;
    assign d_rdata  = resp_q;

    assign stall_fetch = if_req && !if_ack;
    assign stall_pipe  = d_req && !d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = 2'b10;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] m_rdata = '0;
    logic        m_ready = 1'b0;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
    logic        if_ack, d_ack, d_err, m_req, m_we, stall_fetch, stall_pipe;
    logic [1:0]  m_size;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .stall_fetch(stall_fetch), .stall_pipe(stall_pipe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory emulation ----------------
    int mem_delay = 0;   // busy cycles without ready before ready rises
    int mcnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(negedge clk) begin
        if (m_req) begin
            m_ready = (mcnt >= mem_delay);
            m_rdata = mem_word(m_addr);
            if (m_ready) mcnt = 0;
            else mcnt++;
        end else begin
            m_ready = 1'b0;
            m_rdata = 32'hBAD0_BAD0;
            mcnt = 0;
        end
    end

    // ---------------- transaction-level reference model ----------------
    // One access at a time: an access occupies the port until the memory
    // answers or TO port cycles elapse, then one ack cycle follows.
    bit          mdl_active = 0, mdl_resp = 0, mdl_is_data = 0, mdl_last_data = 0;
    bit          mdl_we = 0, mdl_err = 0;
    logic [31:0] mdl_addr = '0, mdl_wdata = '0, mdl_rdata = '0;
    logic [1:0]  mdl_size = 2'b10;
    int          mdl_port_cycles = 0;

    always @(posedge clk) begin
        if (rst) begin
            mdl_active = 0; mdl_resp = 0; mdl_last_data = 0;
            mdl_rdata = '0; mdl_err = 0;
        end else if (mdl_resp) begin
            mdl_resp = 0;
        end else if (mdl_active) begin
            mdl_port_cycles++;
            if (m_ready) begin
                mdl_active = 0; mdl_resp = 1; mdl_err = 0;
                mdl_rdata = mdl_we ? 32'h0 : m_rdata;
            end else if (mdl_port_cycles == TO) begin
                mdl_active = 0; mdl_resp = 1; mdl_err = mdl_is_data;
                mdl_rdata = mdl_is_data ? 32'h0 : 32'h0000_0013;
            end
        end else if (if_req || d_req) begin
            mdl_is_data = d_req && !(if_req && mdl_last_data);
            mdl_last_data = mdl_is_data;
            mdl_port_cycles = 0;
            if (mdl_is_data) begin
                mdl_addr = d_addr; mdl_we = d_we; mdl_size = d_size; mdl_wdata = d_wdata;
            end else begin
                mdl_addr = if_addr; mdl_we = 0; mdl_size = 2'b10; mdl_wdata = '0;
            end
            if (mdl_is_data && d_size == 2'b11) begin
                mdl_resp = 1; mdl_err = 1; mdl_rdata = '0;
            end else begin
                mdl_active = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #3;
        if (chk_en) begin
            logic e_ia, e_da;
            e_ia = mdl_resp && !mdl_is_data;
            e_da = mdl_resp && mdl_is_data;
            chk("m_req", {31'b0, m_req}, {31'b0, mdl_active});
            chk("m_we", {31'b0, m_we}, {31'b0, mdl_active && mdl_we});
            if (mdl_active) begin
                chk("m_addr", m_addr, mdl_addr);
                chk("m_size", {30'b0, m_size}, {30'b0, mdl_size});
                if (mdl_we) chk("m_wdata", m_wdata, mdl_wdata);
            end
            chk("if_ack", {31'b0, if_ack}, {31'b0, e_ia});
            chk("d_ack", {31'b0, d_ack}, {31'b0, e_da});
            chk("d_err", {31'b0, d_err}, {31'b0, e_da && mdl_err});
            if (e_ia) chk("if_rdata", if_rdata, mdl_rdata);
            if (e_da) chk("d_rdata", d_rdata, mdl_rdata);
            chk("stall_fetch", {31'b0, stall_fetch}, {31'b0, if_req && !e_ia});
            chk("stall_pipe", {31'b0, stall_pipe}, {31'b0, d_req && !e_da});
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] f_addr_a[4];
    logic        dw_a[4];
    logic [1:0]  ds_a[4];
    logic [31:0] da_a[4];
    logic [31:0] dd_a[4];

    int          lat_first, mreq_cyc;
    logic [3:0]  ord;
    logic        first_mwe;
    logic [31:0] last_if_rdata, last_d_rdata;
    logic        last_d_err;

    task automatic load_d(input int i);
        d_we = dw_a[i]; d_size = ds_a[i]; d_addr = da_a[i]; d_wdata = dd_a[i];
    endtask

    task automatic run_streams(input int nf, input int nd);
        int fi, di, n;
        bit gf, gd;
        fi = 0; di = 0; n = 0;
        lat_first = -1; mreq_cyc = 0; ord = '0; first_mwe = 1'bx;
        @(negedge clk);
        if (nf > 0) begin if_req = 1; if_addr = f_addr_a[0]; end
        if (nd > 0) begin d_req = 1; load_d(0); end
        while ((fi < nf || di < nd) && n < 80) begin
            @(posedge clk); #3; n++;
            if (n == 1) first_mwe = m_we;
            if (m_req) mreq_cyc++;
            gf = if_ack; gd = d_ack;
            if (gf) last_if_rdata = if_rdata;
            if (gd) begin last_d_rdata = d_rdata; last_d_err = d_err; end
            if ((gf || gd) && lat_first < 0) lat_first = n;
            if (gf || gd) ord = {ord[2:0], gd};
            @(negedge clk);
            if (gf) begin fi++; if (fi < nf) if_addr = f_addr_a[fi]; else if_req = 0; end
            if (gd) begin di++; if (di < nd) load_d(di); else d_req = 0; end
        end
        total++;
        if (fi < nf || di < nd) begin
            bad++;
            $display("FAIL stream_bound: acks fetch=%0d data=%0d expected %0d/%0d", fi, di, nf, nd);
            if_req = 0; d_req = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        repeat (3) @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("rst_m_req", {31'b0, m_req}, 32'h0);
        chk("rst_m_we", {31'b0, m_we}, 32'h0);
        chk("rst_if_ack", {31'b0, if_ack}, 32'h0);
        chk("rst_d_ack", {31'b0, d_ack}, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        rst = 0;

        // single fetch, zero-wait memory
        mem_delay = 0; f_addr_a[0] = 32'h100;
        run_streams(1, 0);
        chk("fetch_lat", lat_first, 2);
        chk("fetch_rdata", last_if_rdata, 32'h0050_0093);
        chk("fetch_mwe", {31'b0, first_mwe}, 32'h0);
        chk("fetch_mreq_cycles", mreq_cyc, 1);

        // conflict streams: data first after reset, then alternating
        f_addr_a[0] = 32'h200; f_addr_a[1] = 32'h204;
        dw_a[0] = 1; ds_a[0] = 2'b10; da_a[0] = 32'h300; dd_a[0] = 32'hDEAD_BEEF;
        dw_a[1] = 1; ds_a[1] = 2'b01; da_a[1] = 32'h302; dd_a[1] = 32'h0000_1234;
        run_streams(2, 2);
        chk("conflict_order", {28'b0, ord}, 32'h0000_000A);
        chk("conflict_first_mwe", {31'b0, first_mwe}, 32'h1);
        chk("conflict_lat", lat_first, 2);

        // load with 4 extra wait cycles: port held 5 cycles
        mem_delay = 4;
        dw_a[0] = 0; ds_a[0] = 2'b10; da_a[0] = 32'h240; dd_a[0] = '0;
        run_streams(0, 1);
        chk("slow_load_mreq_cycles", mreq_cyc, 5);
        chk("slow_load_lat", lat_first, 6);
        chk("slow_load_rdata", last_d_rdata, 32'h0240_FDBF);

        // data timeout
        mem_delay = 1000;
        dw_a[0] = 0; ds_a[0] = 2'b10; da_a[0] = 32'h400;
        run_streams(0, 1);
        chk("d_timeout_mreq_cycles", mreq_cyc, 16);
        chk("d_timeout_lat", lat_first, 17);
        chk("d_timeout_err", {31'b0, last_d_err}, 32'h1);
        chk("d_timeout_rdata", last_d_rdata, 32'h0);

        // fetch timeout returns a NOP
        f_addr_a[0] = 32'h180;
        run_streams(1, 0);
        chk("f_timeout_lat", lat_first, 17);
        chk("f_timeout_rdata", last_if_rdata, 32'h0000_0013);

        // reserved size: no port activity, immediate error ack
        mem_delay = 0;
        dw_a[0] = 1; ds_a[0] = 2'b11; da_a[0] = 32'h500; dd_a[0] = 32'h5555_AAAA;
        run_streams(0, 1);
        chk("badsize_mreq_cycles", mreq_cyc, 0);
        chk("badsize_lat", lat_first, 1);
        chk("badsize_err", {31'b0, last_d_err}, 32'h1);

        // byte store, short wait
        mem_delay = 2;
        dw_a[0] = 1; ds_a[0] = 2'b00; da_a[0] = 32'h601; dd_a[0] = 32'h0000_00C3;
        run_streams(0, 1);
        chk("byte_store_lat", lat_first, 4);
        chk("byte_store_rdata", last_d_rdata, 32'h0);

        // request dropped mid-access still gets its ack
        mem_delay = 3;
        @(negedge clk);
        d_req = 1; d_we = 0; d_size = 2'b01; d_addr = 32'h2A2;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        d_req = 0;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(posedge clk); #3;
            if (d_ack) begin got = 1; last_d_rdata = d_rdata; end
        end
        chk("drop_req_ack", got, 1);
        chk("drop_req_rdata", last_d_rdata, 32'h02A2_FD5D);

        // reset during the third port cycle of a load
        mem_delay = 1000;
        @(negedge clk);
        d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 32'h700;
        @(posedge clk); @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1; d_req = 0;
        @(posedge clk); #3;
        chk("rst_busy_m_req", {31'b0, m_req}, 32'h0);
        chk("rst_busy_d_ack", {31'b0, d_ack}, 32'h0);
        @(negedge clk);
        rst = 0;
        got = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #3;
            if (d_ack) got++;
        end
        chk("rst_busy_no_late_ack", got, 0);
        mem_delay = 0; f_addr_a[0] = 32'h100;
        run_streams(1, 0);
        chk("post_rst_fetch_lat", lat_first, 2);
        chk("post_rst_fetch_rdata", last_if_rdata, 32'h0050_0093);

        repeat (3) @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
